// File: rtl/fifo_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_serial_tx
// Brief    : Drains a FIFO one word at a time and sends each word as a
//            start bit, FIFO_width data bits LSB-first, and a stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_serial_tx #(
    parameter int FIFO_width = 16,
    parameter int BIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_width-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  enable,
    output logic                  ser_out,
    output logic                  ser_busy,
    output logic                  word_done,
    output logic [7:0]            words_sent
);

    localparam int c_CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int c_BIT_W = (FIFO_width > 1) ? $clog2(FIFO_width) : 1;
    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(BIT_CYCLES - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FIFO_width - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_LATCH = 3'd2;
    localparam logic [2:0] c_S_START = 3'd3;
    localparam logic [2:0] c_S_DATA  = 3'd4;
    localparam logic [2:0] c_S_STOP  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_CYC_W-1:0]    r_cyc_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [FIFO_width-1:0] r_shift;
    logic [7:0]            r_words_sent;
    logic                  w_bit_end;
    logic                  w_go;
    logic                  w_in_line;

    assign w_bit_end  = (r_cyc_cnt == c_CYC_LAST);
    assign w_go       = enable && !fifo_empty;
    assign w_in_line  = (r_state == c_S_START) || (r_state == c_S_DATA) || (r_state == c_S_STOP);
    assign words_sent = r_words_sent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (w_go) w_next_state = c_S_FETCH;
            c_S_FETCH: w_next_state = c_S_LATCH;
            c_S_LATCH: w_next_state = c_S_START;
            c_S_START: if (w_bit_end) w_next_state = c_S_DATA;
            c_S_DATA:  if (w_bit_end && (r_bit_cnt == c_BIT_LAST)) w_next_state = c_S_STOP;
            c_S_STOP:  if (w_bit_end) w_next_state = w_go ? c_S_FETCH : c_S_IDLE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        ser_out    = 1'b1;
        fifo_rd_en = 1'b0;
        ser_busy   = (r_state != c_S_IDLE);
        word_done  = 1'b0;
        case (r_state)
            c_S_FETCH: fifo_rd_en = 1'b1;
            c_S_START: ser_out = 1'b0;
            c_S_DATA:  ser_out = r_shift[0];
            c_S_STOP:  word_done = w_bit_end;
            default:   ser_out = 1'b1;
        endcase
    end

    // Bit timing, shift register and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_words_sent <= '0;
        end else begin
            if (w_in_line) begin
                r_cyc_cnt <= w_bit_end ? '0 : r_cyc_cnt + 1'b1;
            end else begin
                r_cyc_cnt <= '0;
            end

            if (r_state != c_S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
            end

            if (r_state == c_S_LATCH) begin
                r_shift <= fifo_data;
            end else if ((r_state == c_S_DATA) && w_bit_end) begin
                r_shift <= {1'b0, r_shift[FIFO_width-1:1]};
            end

            if (word_done) begin
                r_words_sent <= r_words_sent + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_serial_tx
// Brief    : Self-checking bench: cycle timeline reference model, scenario
//            table, reset and counter-wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_serial_tx;

    localparam int W  = 16;
    localparam int BC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en, ser_out, ser_busy, word_done;
    logic [7:0]   words_sent;

    logic         en1 = 1'b0;
    logic [W-1:0] data1 = '0;
    logic         empty1 = 1'b1;
    logic         rd1, ser1, busy1, done1;
    logic [7:0]   ws1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_serial_tx #(.FIFO_width(W), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .enable(enable), .ser_out(ser_out),
        .ser_busy(ser_busy), .word_done(word_done), .words_sent(words_sent)
    );

    fifo_serial_tx #(.FIFO_width(W), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_data(data1), .fifo_empty(empty1),
        .fifo_rd_en(rd1), .enable(en1), .ser_out(ser1),
        .ser_busy(busy1), .word_done(done1), .words_sent(ws1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural FIFOs: read data appears the cycle after a read request
    logic [W-1:0] fq[$];
    logic [W-1:0] fq1[$];
    logic [W-1:0] sent1[$];
    logic [W-1:0] pop1_w;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() > 0) fifo_data <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
        if (rd1) begin
            if (fq1.size() > 0) begin
                pop1_w = fq1.pop_front();
                data1 <= pop1_w;
                sent1.push_back(pop1_w);
            end
            empty1 <= (fq1.size() == 0);
        end
    end

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Reference model: timeline of expected {ser, rd_en, busy, done} per cycle
    typedef struct packed {logic ser; logic rd; logic busy; logic done;} cyc_t;
    cyc_t     exp_q[$];
    cyc_t     cur = cyc_t'(4'b1000);
    logic [7:0] exp_ws = 8'd0;
    int       rd_seen = 0;

    task automatic push_frame(input logic [W-1:0] w);
        exp_q.push_back(cyc_t'(4'b1110));
        exp_q.push_back(cyc_t'(4'b1010));
        for (int i = 0; i < BC; i++) exp_q.push_back(cyc_t'(4'b0010));
        for (int b = 0; b < W; b++)
            for (int i = 0; i < BC; i++) exp_q.push_back(cyc_t'({w[b], 3'b010}));
        for (int i = 0; i < BC - 1; i++) exp_q.push_back(cyc_t'(4'b1010));
        exp_q.push_back(cyc_t'(4'b1011));
    endtask

    task automatic tick();
        if (!rst_n) begin
            exp_q.delete();
            cur    = cyc_t'(4'b1000);
            exp_ws = 8'd0;
        end else begin
            if (cur.done) exp_ws = exp_ws + 8'd1;
            if (exp_q.size() == 0 && enable && fq.size() > 0) push_frame(fq[0]);
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : cyc_t'(4'b1000);
        end
        @(negedge clk);
        if (fifo_rd_en) rd_seen++;
        check("ser_out",    {31'd0, ser_out},    {31'd0, cur.ser});
        check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, cur.rd});
        check("ser_busy",   {31'd0, ser_busy},   {31'd0, cur.busy});
        check("word_done",  {31'd0, word_done},  {31'd0, cur.done});
        check("words_sent", {24'd0, words_sent}, {24'd0, exp_ws});
    endtask

    task automatic run_idle(input int max_cycles, input string name);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            tick();
            if (exp_q.size() == 0 && cur == cyc_t'(4'b1000) && !(enable && fq.size() > 0)) break;
        end
        checks++;
        if (i >= max_cycles) begin
            failures++;
            $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, i);
        end
    endtask

    // Monitor for the BIT_CYCLES=1 instance
    logic [17:0] hist1 = '0;
    logic        wrap_on = 1'b0;
    logic        ws_pending = 1'b0;
    int          done_cnt1 = 0;
    int          rd1_cnt = 0;
    int          cyc1 = 0;
    int          last_done1 = 0;
    logic [W-1:0] exp1;
    logic [W-1:0] dec1;

    always @(negedge clk) begin
        cyc1++;
        hist1 = {hist1[16:0], ser1};
        if (wrap_on && rd1) rd1_cnt++;
        if (ws_pending) begin
            check("wrap_words_sent", {24'd0, ws1}, {24'd0, done_cnt1[7:0]});
            ws_pending = 1'b0;
        end
        if (wrap_on && done1) begin
            done_cnt1++;
            for (int k = 0; k < W; k++) dec1[k] = hist1[16-k];
            exp1 = (sent1.size() > 0) ? sent1.pop_front() : 16'hxxxx;
            check("wrap_frame", {14'd0, hist1[17], dec1, ser1}, {14'd0, 1'b0, exp1, 1'b1});
            if (done_cnt1 > 1) check("wrap_gap", cyc1 - last_done1, 20);
            last_done1 = cyc1;
            ws_pending = 1'b1;
        end
    end

    typedef struct {
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        int           nw;
        int           drop_at;
        logic [7:0]   exp_ws;
        logic         exp_empty;
        int           exp_rd;
    } vec_t;

    vec_t vec[5];

    initial begin
        int rd0;
        int i;
        vec[0] = '{16'hFF01, 16'h0000, 1, 0,  8'd1, 1'b1, 1};
        vec[1] = '{16'h539E, 16'hABCD, 2, 0,  8'd3, 1'b1, 2};
        vec[2] = '{16'h1234, 16'h5678, 2, 30, 8'd4, 1'b0, 1};
        vec[3] = '{16'h8001, 16'h0000, 1, 0,  8'd6, 1'b1, 2};
        vec[4] = '{16'hFFFF, 16'h0000, 2, 0,  8'd8, 1'b1, 2};

        // Reset held, then release with an empty FIFO
        enable = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();

        for (int v = 0; v < 5; v++) begin
            push(vec[v].w0);
            if (vec[v].nw > 1) push(vec[v].w1);
            rd0 = rd_seen;
            enable = 1'b1;
            if (vec[v].drop_at > 0) begin
                repeat (vec[v].drop_at) tick();
                enable = 1'b0;
            end
            run_idle(800, "vector");
            check("vec_words_sent", {24'd0, words_sent}, {24'd0, vec[v].exp_ws});
            check("vec_fifo_empty", {31'd0, fifo_empty}, {31'd0, vec[v].exp_empty});
            check("vec_rd_pulses", rd_seen - rd0, vec[v].exp_rd);
        end

        // Randomized traffic with enable toggling
        for (int n = 0; n < 2000; n++) begin
            tick();
            if ($urandom_range(0, 7) == 0 && fq.size() < 6) push(16'($urandom));
            if ($urandom_range(0, 31) == 0) enable = ~enable;
        end
        enable = 1'b1;
        run_idle(2000, "random");

        // Asynchronous reset in the middle of DATA
        push(16'hC3A5);
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ser_out",    {31'd0, ser_out},    32'd1);
        check("rst_ser_busy",   {31'd0, ser_busy},   32'd0);
        check("rst_rd_en",      {31'd0, fifo_rd_en}, 32'd0);
        check("rst_words_sent", {24'd0, words_sent}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        push(16'h0F5A);
        run_idle(400, "post_reset");
        check("post_reset_words", {24'd0, words_sent}, 32'd1);

        // 256-frame wrap on the BIT_CYCLES=1 instance
        for (int n = 0; n < 256; n++) fq1.push_back(16'($urandom));
        empty1  = 1'b0;
        wrap_on = 1'b1;
        en1     = 1'b1;
        for (i = 0; i < 8000; i++) begin
            tick();
            if (done_cnt1 == 256 && !busy1 && !ws_pending) break;
        end
        checks++;
        if (i >= 8000) begin
            failures++;
            $display("FAIL wrap_timeout: got %0d frames, required 256", done_cnt1);
        end
        check("wrap_done_count", done_cnt1, 256);
        check("wrap_final_ws", {24'd0, ws1}, 32'd0);
        check("wrap_rd_count", rd1_cnt, 256);
        check("wrap_empty", {31'd0, empty1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
